// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix multiplier: baud-select encodings,
// the baud divisor function, size defaults and the result-TX FSM states.
package matmul_pkg;

  localparam int unsigned MAX_N_DEF  = 4;
  localparam int unsigned ELEM_W_DEF = 16;

  typedef enum logic [1:0] {
    BAUD_4800   = 2'b00,
    BAUD_9600   = 2'b01,
    BAUD_57600  = 2'b10,
    BAUD_115200 = 2'b11
  } baud_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_LOAD,
    ST_SEND,
    ST_FINISH
  } tx_state_e;

  // Cycles per bit, rounded to nearest.
  function automatic logic [15:0] baud_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    int unsigned q;
    q = (clk_hz + baud / 2) / baud;
    return q[15:0];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serializer for one byte. A new byte is accepted in the last cycle of
// the current stop bit, so successive frames run without any idle gap.
module uart_tx_byte (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] div,
  input  logic [7:0]  data,
  input  logic        valid,
  output logic        ready,
  output logic        tx
);

  logic        active_q, active_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [8:0]  frame_q, frame_d;
  logic        tx_q, tx_d;
  logic        bit_end;
  logic        stop_end;

  assign bit_end  = (cnt_q == div - 16'd1);
  assign stop_end = active_q && (bit_q == 4'd9) && bit_end;
  assign ready    = !active_q || stop_end;
  assign tx       = tx_q;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    tx_d     = tx_q;
    if (ready && valid) begin
      // Frame start: counters reload here, so timing never drifts.
      active_d = 1'b1;
      cnt_d    = '0;
      bit_d    = '0;
      frame_d  = {1'b1, data};
      tx_d     = 1'b0;
    end else if (stop_end) begin
      active_d = 1'b0;
      tx_d     = 1'b1;
    end else if (active_q) begin
      if (bit_end) begin
        cnt_d   = '0;
        bit_d   = bit_q + 4'd1;
        tx_d    = frame_q[0];
        frame_d = {1'b1, frame_q[8:1]};
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      frame_q  <= '1;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/matrix_result_tx.sv
// Streams the N x N result matrix out of the UART: a size header byte, then
// every element in row-major order, most-significant byte first.
module matrix_result_tx
  import matmul_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned MAX_N  = MAX_N_DEF,
  parameter int unsigned ELEM_W = ELEM_W_DEF,
  parameter int unsigned AW     = $clog2(MAX_N * MAX_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        n,
  input  logic [1:0]        b_sel,
  output logic [AW-1:0]     rd_addr,
  input  logic [ELEM_W-1:0] rd_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BPE       = ELEM_W / 8;
  localparam int unsigned BW        = (BPE > 1) ? $clog2(BPE) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(BPE - 1);
  localparam logic [7:0]  MAX_N8    = 8'(MAX_N);

  localparam logic [15:0] DIV_4800   = baud_div(CLK_HZ, 4800);
  localparam logic [15:0] DIV_9600   = baud_div(CLK_HZ, 9600);
  localparam logic [15:0] DIV_57600  = baud_div(CLK_HZ, 57600);
  localparam logic [15:0] DIV_115200 = baud_div(CLK_HZ, 115200);

  tx_state_e         state_q, state_d;
  logic [7:0]        n_q, n_d;
  logic [15:0]       div_q, div_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [BW-1:0]     byte_q, byte_d;
  logic [ELEM_W-1:0] sh_q, sh_d;
  logic              done_q, done_d;

  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        tx_data;
  logic [15:0]       div_sel;
  logic [15:0]       nn;
  logic              n_ok;
  logic              last_elem;
  logic              last_byte;

  always_comb begin
    div_sel = DIV_115200;
    unique case (baud_sel_e'(b_sel))
      BAUD_4800:   div_sel = DIV_4800;
      BAUD_9600:   div_sel = DIV_9600;
      BAUD_57600:  div_sel = DIV_57600;
      BAUD_115200: div_sel = DIV_115200;
      default:     div_sel = DIV_115200;
    endcase
  end

  assign nn        = 16'(n_q) * 16'(n_q);
  assign n_ok      = (n_q != '0) && (n_q <= MAX_N8);
  assign last_elem = (16'(idx_q) == nn - 16'd1);
  assign last_byte = (byte_q == LAST_BYTE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_HDR;
      ST_HDR:    if (tx_ready) state_d = n_ok ? ST_FETCH : ST_FINISH;
      ST_FETCH:  state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_SEND;
      ST_SEND:   if (tx_ready && last_byte) state_d = last_elem ? ST_FINISH : ST_FETCH;
      ST_FINISH: if (tx_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_valid = (state_q == ST_HDR) || (state_q == ST_SEND);
    tx_data  = (state_q == ST_HDR) ? n_q : sh_q[ELEM_W-1 -: 8];
  end

  // FETCH/LOAD of the next element happen while its predecessor's last
  // frame is still on the wire, so SEND is always ready at the stop edge.
  always_comb begin
    n_d    = n_q;
    div_d  = div_q;
    idx_d  = idx_q;
    addr_d = addr_q;
    byte_d = byte_q;
    sh_d   = sh_q;
    done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d   = n;
          div_d = div_sel;
        end
      end
      ST_HDR: begin
        if (tx_ready && n_ok) begin
          idx_d  = '0;
          addr_d = '0;
        end
      end
      ST_LOAD: begin
        sh_d   = rd_data;
        byte_d = '0;
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (!last_byte) begin
            sh_d   = sh_q << 8;
            byte_d = byte_q + 1'b1;
          end else if (!last_elem) begin
            idx_d  = idx_q + 1'b1;
            addr_d = idx_q + 1'b1;
          end
        end
      end
      ST_FINISH: begin
        if (tx_ready) done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q    <= '0;
      div_q  <= DIV_115200;
      idx_q  <= '0;
      addr_q <= '0;
      byte_q <= '0;
      sh_q   <= '0;
      done_q <= 1'b0;
    end else begin
      n_q    <= n_d;
      div_q  <= div_d;
      idx_q  <= idx_d;
      addr_q <= addr_d;
      byte_q <= byte_d;
      sh_q   <= sh_d;
      done_q <= done_d;
    end
  end

  uart_tx_byte u_tx (
    .clk   (clk),
    .rst   (rst),
    .div   (div_q),
    .data  (tx_data),
    .valid (tx_valid),
    .ready (tx_ready),
    .tx    (tx)
  );

  assign rd_addr = addr_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_matrix_result_tx.sv
// Directed bench for matrix_result_tx: decodes the UART stream, checks frame
// timing, done timing, RAM address order and asynchronous reset behaviour.
module tb_matrix_result_tx;

  // 1 MHz clock keeps runs short: DIV = 208, 104, 17, 9.
  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned MAX_N  = 4;
  localparam int unsigned ELEM_W = 16;
  localparam int unsigned AW     = 4;
  localparam int unsigned D115   = 9;
  localparam int unsigned D9600  = 104;

  logic              clk;
  logic              rst;
  logic              start;
  logic [7:0]        n;
  logic [1:0]        b_sel;
  logic [AW-1:0]     rd_addr;
  logic [ELEM_W-1:0] rd_data;
  logic              tx;
  logic              busy;
  logic              done;

  matrix_result_tx #(
    .CLK_HZ (CLK_HZ),
    .MAX_N  (MAX_N),
    .ELEM_W (ELEM_W),
    .AW     (AW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .n       (n),
    .b_sel   (b_sel),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [16];
  always @(posedge clk) rd_data <= mem[rd_addr];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // UART receiver: samples mid-bit, records each byte and its start edge.
  logic [7:0]  rx_q [$];
  int unsigned rxt_q [$];
  int unsigned cur_div = D115;
  int          fe_cnt = 0;

  initial begin : rx_mon
    logic [7:0]  b;
    int unsigned t;
    int unsigned d;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        t = cyc;
        d = cur_div;
        repeat (d / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (d) @(negedge clk);
          b[i] = tx;
        end
        repeat (d) @(negedge clk);
        if (tx !== 1'b1) fe_cnt++;
        rx_q.push_back(b);
        rxt_q.push_back(t);
      end
    end
  end

  int          done_cnt = 0;
  int unsigned done_cyc = 0;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  logic [AW-1:0] last_addr;
  int unsigned   addr_q [$];
  always @(negedge clk) begin
    if (rd_addr !== last_addr) addr_q.push_back(32'(rd_addr));
    last_addr = rd_addr;
  end

  logic [7:0] exp_q [$];

  function automatic int unsigned low_bits(input logic [7:0] v);
    int unsigned c;
    c = 1;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return c;
      c++;
    end
    return c;
  endfunction

  task automatic wait_tx(input logic v, input int unsigned lim, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < lim; i++) begin
      if (tx === v) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic transfer(input string tag, input logic [7:0] nv, input logic [1:0] bs,
                          input int unsigned d, input bit meddle);
    int unsigned k, t0, t1, frames, bad, budget;
    int          dc0;
    bit          ok;
    frames = exp_q.size();
    rx_q.delete();
    rxt_q.delete();
    addr_q.delete();
    cur_div = d;
    fe_cnt  = 0;
    dc0     = done_cnt;
    @(negedge clk);
    start = 1'b1;
    n     = nv;
    b_sel = bs;
    @(negedge clk);
    start = 1'b0;
    k     = cyc;
    check_eq({tag, " busy_hi"}, 32'(busy), 32'd1);
    wait_tx(1'b0, 100, ok);
    t0 = cyc;
    check_eq({tag, " start_lat"}, ok ? t0 - k : 32'hFFFF_FFFF, 32'd1);
    wait_tx(1'b1, 20 * d, ok);
    t1 = cyc;
    check_eq({tag, " hdr_low"}, ok ? t1 - t0 : 32'hFFFF_FFFF, low_bits(nv) * d);
    if (meddle) begin
      repeat (3 * d) @(negedge clk);
      start = 1'b1;
      n     = 8'd1;
      b_sel = 2'b00;
      @(negedge clk);
      start = 1'b0;
    end
    budget = frames * 10 * d + 200;
    for (int unsigned i = 0; i < budget && done_cnt == dc0; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    check_eq({tag, " done_cnt"}, 32'(done_cnt - dc0), 32'd1);
    check_eq({tag, " done_time"}, done_cyc - t0, frames * 10 * d);
    check_eq({tag, " busy_lo"}, 32'(busy), 32'd0);
    check_eq({tag, " nbytes"}, rx_q.size(), frames);
    check_eq({tag, " framing"}, 32'(fe_cnt), 32'd0);
    for (int i = 0; i < rx_q.size() && i < frames; i++)
      check_eq($sformatf("%s byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    bad = 0;
    for (int i = 1; i < rxt_q.size(); i++)
      if (rxt_q[i] - rxt_q[i-1] != 10 * d) bad++;
    check_eq({tag, " gaps"}, bad, 32'd0);
  endtask

  initial begin : main
    int unsigned k;
    int          dc0;
    rst   = 1'b0;
    start = 1'b0;
    n     = '0;
    b_sel = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check_eq("rst tx", 32'(tx), 32'd1);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst done", 32'(done), 32'd0);
    check_eq("rst rd_addr", 32'(rd_addr), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    mem[0] = 16'd19; mem[1] = 16'd22; mem[2] = 16'd43; mem[3] = 16'd50;
    exp_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h16, 8'h00, 8'h2B, 8'h00, 8'h32};
    transfer("n2_b11", 8'd2, 2'b11, D115, 1'b0);
    transfer("n2_b01", 8'd2, 2'b01, D9600, 1'b0);

    exp_q = '{8'h00};
    transfer("n0", 8'd0, 2'b11, D115, 1'b0);
    check_eq("n0 reads", addr_q.size(), 32'd0);
    exp_q = '{8'h05};
    transfer("n5", 8'd5, 2'b11, D115, 1'b0);
    check_eq("n5 reads", addr_q.size(), 32'd0);

    exp_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h16, 8'h00, 8'h2B, 8'h00, 8'h32};
    transfer("meddle", 8'd2, 2'b11, D115, 1'b1);

    exp_q = '{8'h03};
    for (int i = 0; i < 9; i++) begin
      mem[i] = {8'(8'h10 + i), 8'(8'hC0 + i)};
      exp_q.push_back(8'(8'h10 + i));
      exp_q.push_back(8'(8'hC0 + i));
    end
    transfer("n3", 8'd3, 2'b11, D115, 1'b0);
    check_eq("n3 naddr", addr_q.size(), 32'd9);
    for (int i = 0; i < addr_q.size() && i < 9; i++)
      check_eq($sformatf("n3 addr%0d", i), addr_q[i], 32'(i));

    // Abort in the middle of the third frame.
    cur_div = D115;
    @(negedge clk);
    start = 1'b1;
    n     = 8'd2;
    b_sel = 2'b11;
    @(negedge clk);
    start = 1'b0;
    k     = cyc;
    while (cyc < k + 1 + 2 * 10 * D115 + 5 * D115) @(negedge clk);
    dc0 = done_cnt;
    rst = 1'b0;
    #1;
    check_eq("abort tx", 32'(tx), 32'd1);
    check_eq("abort busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (30 * D115) @(negedge clk);
    check_eq("abort no_done", 32'(done_cnt - dc0), 32'd0);
    check_eq("abort idle_tx", 32'(tx), 32'd1);

    mem[0] = 16'hABCD;
    exp_q = '{8'h01, 8'hAB, 8'hCD};
    transfer("post_rst", 8'd1, 2'b11, D115, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
